regu_sp_ctrl: RTL and testbench
===============================

# regu_sp_ctrl

Set-point sequencer feeding the regulation interlock. Accepts commanded output targets over a valid/ready handshake and ramps a signed 32-bit fixed-point set point toward each target at a programmed slew. It drives the interlock's set-point and enable inputs and services its fault flag: it forces the output to zero on a fault, then issues the interlock clear pulse on request. Sits between the host register block and the regulation interlock monitor.

## Interface
- W, 32: set-point / target width, signed two's complement.
- CLR_TIMEOUT, 16: cycles to wait in CLEAR for the interlock flag to drop.
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  target command valid.
- i_cmd_target  in  W  signed target set point.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_step  in  W  unsigned step magnitude per ramp tick; 0 = jump directly to target.
- i_period  in  32  ramp tick period minus one; 0 = one tick every cycle.
- i_regu_en  in  1  host enable for interlock supervision.
- i_regu_flag  in  1  interlock fault flag (level).
- i_clr_req  in  1  host clear request (pulse).
- o_set_point  out  W  set point to the interlock and regulator.
- o_regu_en  out  1  i_regu_en gated off in FAULT/CLEAR.
- o_intl_clr  out  1  one-cycle interlock clear pulse.
- o_done  out  1  one-cycle pulse when the set point reaches the target.
- o_fault  out  1  high in FAULT and CLEAR.
- o_state  out  3  current state encoding.

## Operation
- States: IDLE=0, RAMP=1, FAULT=2, CLEAR=3.
- o_cmd_ready = (state==IDLE || state==RAMP) && ~i_regu_flag. This is combinational.
- IDLE: on accept, latch the target, reset the tick counter to 0, and go to RAMP.
- RAMP: on accept (retarget), latch the new target. The tick counter is not reset.
- Tick counter: when cnt==i_period, a tick occurs and cnt<=0. Otherwise cnt<=cnt+1.
- Tick step:
  - diff = target − sp, computed at W+1 bits signed.
  - If i_step==0 or |diff| ≤ i_step: sp<=target, o_done pulses, next state is IDLE.
  - Otherwise sp <= sp ± i_step, with the sign taken from diff. Compute at W+1 bits; the result cannot overshoot the target, so no saturation is needed beyond the W+1-bit intermediate.
- A target equal to the current sp still enters RAMP and completes on the first tick.
- Fault entry: i_regu_flag high in IDLE or RAMP causes FAULT next cycle, with sp<=0, target<=0, and cnt<=0.
  - Fault has priority over a simultaneous command or tick.
- FAULT:
  - o_set_point is held at 0 and commands are refused.
  - i_clr_req causes a one-cycle o_intl_clr pulse (asserted the cycle after the request), then state goes to CLEAR with the timeout counter at 0.
- CLEAR:
  - If i_regu_flag==0, go to IDLE.
  - Else if the timeout counter == CLR_TIMEOUT−1, return to FAULT (no new clear pulse).
  - Otherwise increment the timeout counter.
- i_clr_req outside FAULT is ignored.
- o_regu_en = i_regu_en && state∉{FAULT,CLEAR}, registered.

## Timing
- Reset values: state IDLE, o_set_point 0, target 0, both counters 0. o_intl_clr, o_done, o_fault and o_regu_en are all 0.
- Reset mid-operation (any state) returns everything to the reset values on the next edge. No clear pulse is emitted.
- All outputs except o_cmd_ready are registered.
- Command accepted at edge N: RAMP from N+1. The first tick is in the RAMP cycle where cnt==i_period, i.e. i_period+1 cycles after entry. The new o_set_point is visible the cycle after the tick.
- o_done is asserted in the same cycle as the final o_set_point value.
- Flag seen at edge N: o_set_point=0, o_fault=1 and o_regu_en=0 from N+1.
- Clear request at edge N (in FAULT): o_intl_clr=1 for exactly cycle N+1, and state=CLEAR from N+1.
- Changes to i_step or i_period during RAMP take effect at the next tick comparison.

## Structure
- Package regu_pkg: the state encodings, default W, and the CLR_TIMEOUT default.
- Sub-module regu_ramp_step: the registered tick counter plus the next-sp / reached computation, with W+1-bit difference and absolute-value logic. The FSM, handshake and fault/clear logic stay in the top level.

## Test plan
- i_period=0, i_step=10, command 35 from 0 → o_set_point goes 10, 20, 30, 35 on consecutive cycles; o_done pulses with 35; state returns to IDLE.
- i_period=3, i_step=0, command −1000 → single jump to −1000 on the 4th RAMP cycle, with o_done pulsing alongside it.
- Retarget: ramping 0→100 with step 10, period 0; at sp=40, command 20 → sp goes 30, 20, then done. The counter is not reset.
- i_regu_flag pulsed in RAMP at sp=50 in the same cycle as i_cmd_valid → o_cmd_ready=0; next cycle o_set_point=0, o_fault=1, o_regu_en=0.
- In FAULT: assert i_clr_req, then drop i_regu_flag 2 cycles later → one-cycle o_intl_clr, CLEAR, then IDLE. Repeat with the flag held high → back to FAULT after 16 cycles with no second pulse.
- Assert i_rst during RAMP and during CLEAR → all outputs at reset values next cycle and o_intl_clr never asserted.

Source files
------------

// File: rtl/regu_sp_ctrl_pkg.sv
// Package regu_pkg: shared definitions for the set-point sequencer.
//   REGU_W            default set-point / target width (signed)
//   REGU_CLR_TIMEOUT  default cycles to wait in CLEAR for the interlock flag
//   ST_*              state encodings visible on o_state
//   is_fault_state()  true for states in which the output is forced safe
package regu_pkg;

  localparam int REGU_W           = 32;
  localparam int REGU_CLR_TIMEOUT = 16;

  typedef logic [2:0] regu_state_t;

  localparam regu_state_t ST_IDLE  = 3'd0;
  localparam regu_state_t ST_RAMP  = 3'd1;
  localparam regu_state_t ST_FAULT = 3'd2;
  localparam regu_state_t ST_CLEAR = 3'd3;

  function automatic logic is_fault_state(input regu_state_t s);
    return (s == ST_FAULT) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/regu_sp_ctrl_if.sv
// Command handshake between the host register block and the sequencer.
//   cmd_valid   host -> sequencer  target command valid
//   cmd_target  host -> sequencer  signed target set point
//   cmd_ready   sequencer -> host  command accepted when valid & ready
// master: host side, slave: sequencer side.
interface regu_sp_ctrl_if
  import regu_pkg::*;
#(
  parameter int W = REGU_W
) ();

  logic         cmd_valid;
  logic [W-1:0] cmd_target;
  logic         cmd_ready;

  modport master (output cmd_valid, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, output cmd_ready);

endinterface

// File: rtl/regu_sp_ctrl_ramp_step.sv
// regu_ramp_step: ramp tick timer and next-set-point arithmetic.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_cnt_clr     force the tick counter to 0
//   i_cnt_en      advance the tick counter (only while ramping)
//   i_period      tick period minus one
//   i_step        unsigned step magnitude, 0 = jump to target
//   i_sp          current set point (signed)
//   i_target      target the step moves toward (signed)
//   o_tick        counter is at its terminal value this cycle
//   o_next_sp     set point after a tick
//   o_reached     a tick this cycle lands exactly on the target
module regu_ramp_step
  import regu_pkg::*;
#(
  parameter int W = REGU_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cnt_clr,
  input  logic         i_cnt_en,
  input  logic [31:0]  i_period,
  input  logic [W-1:0] i_step,
  input  logic [W-1:0] i_sp,
  input  logic [W-1:0] i_target,
  output logic         o_tick,
  output logic [W-1:0] o_next_sp,
  output logic         o_reached
);

  logic [31:0] cnt;
  logic [W:0]  diff;
  logic [W:0]  mag;
  logic        neg;

  assign o_tick = i_cnt_en && (cnt == i_period);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      cnt <= '0;
    end else if (i_cnt_en) begin
      cnt <= o_tick ? 32'd0 : cnt + 32'd1;
    end
  end

  // One extra bit so target - sp cannot wrap for any pair of W-bit values.
  always_comb begin
    diff      = {i_target[W-1], i_target} - {i_sp[W-1], i_sp};
    neg       = diff[W];
    mag       = neg ? (~diff + 1'b1) : diff;
    o_reached = (i_step == '0) || (mag <= {1'b0, i_step});
    // A partial step lands strictly between sp and target, so the W-bit
    // modular sum/difference is already the exact signed result.
    if (o_reached) begin
      o_next_sp = i_target;
    end else if (neg) begin
      o_next_sp = i_sp - i_step;
    end else begin
      o_next_sp = i_sp + i_step;
    end
  end

endmodule

// File: rtl/regu_sp_ctrl.sv
// regu_sp_ctrl: set-point sequencer in front of the regulation interlock.
//   i_clk, i_rst   clock, synchronous active-high reset
//   cmd            command handshake (slave side): valid/target/ready
//   i_step         unsigned step per ramp tick, 0 = jump to target
//   i_period       ramp tick period minus one
//   i_regu_en      host enable for interlock supervision
//   i_regu_flag    interlock fault flag (level)
//   i_clr_req      host clear request (pulse)
//   o_set_point    set point to interlock and regulator
//   o_regu_en      i_regu_en gated off while faulted
//   o_intl_clr     one-cycle interlock clear pulse
//   o_done         one-cycle pulse with the final set point of a ramp
//   o_fault        high in FAULT and CLEAR
//   o_state        current state encoding
//
// state | meaning
// IDLE  | set point holds, waiting for a target command
// RAMP  | stepping the set point toward the target once per tick
// FAULT | interlock tripped, set point forced to 0, waiting for clear request
// CLEAR | clear pulse issued, waiting for the interlock flag to drop
module regu_sp_ctrl
  import regu_pkg::*;
#(
  parameter int W           = REGU_W,
  parameter int CLR_TIMEOUT = REGU_CLR_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  regu_sp_ctrl_if.slave cmd,
  input  logic [W-1:0]  i_step,
  input  logic [31:0]   i_period,
  input  logic          i_regu_en,
  input  logic          i_regu_flag,
  input  logic          i_clr_req,
  output logic [W-1:0]  o_set_point,
  output logic          o_regu_en,
  output logic          o_intl_clr,
  output logic          o_done,
  output logic          o_fault,
  output logic [2:0]    o_state
);

  localparam logic [15:0] CLR_LAST = 16'(CLR_TIMEOUT - 1);

  regu_state_t  state;
  regu_state_t  state_d;
  logic [W-1:0] target;
  logic [W-1:0] target_d;
  logic [W-1:0] sp_d;
  logic [W-1:0] eff_target;
  logic [W-1:0] next_sp;
  logic [15:0]  clr_cnt;
  logic [15:0]  clr_cnt_d;
  logic         in_run;
  logic         accept;
  logic         fault_entry;
  logic         cnt_clr;
  logic         cnt_en;
  logic         tick;
  logic         reached;
  logic         done_d;
  logic         intl_clr_d;

  assign in_run        = (state == ST_IDLE) || (state == ST_RAMP);
  assign cmd.cmd_ready = in_run && !i_regu_flag;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign fault_entry   = in_run && i_regu_flag;

  // A retarget arriving on a tick steers that tick toward the new target.
  assign eff_target = ((state == ST_RAMP) && accept) ? cmd.cmd_target : target;

  // Retargeting while ramping keeps the tick phase; only a fresh start or a
  // fault restarts it.
  assign cnt_clr = fault_entry || ((state == ST_IDLE) && accept);
  assign cnt_en  = (state == ST_RAMP) && !i_regu_flag;

  regu_ramp_step #(
    .W(W)
  ) u_ramp_step (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_cnt_clr (cnt_clr),
    .i_cnt_en  (cnt_en),
    .i_period  (i_period),
    .i_step    (i_step),
    .i_sp      (o_set_point),
    .i_target  (eff_target),
    .o_tick    (tick),
    .o_next_sp (next_sp),
    .o_reached (reached)
  );

  always_comb begin
    state_d    = state;
    sp_d       = o_set_point;
    target_d   = target;
    clr_cnt_d  = clr_cnt;
    done_d     = 1'b0;
    intl_clr_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fault_entry) begin
          state_d  = ST_FAULT;
          sp_d     = '0;
          target_d = '0;
        end else if (accept) begin
          target_d = cmd.cmd_target;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (fault_entry) begin
          state_d  = ST_FAULT;
          sp_d     = '0;
          target_d = '0;
        end else begin
          if (accept) begin
            target_d = cmd.cmd_target;
          end
          if (tick) begin
            sp_d = next_sp;
            if (reached) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_FAULT: begin
        sp_d = '0;
        if (i_clr_req) begin
          intl_clr_d = 1'b1;
          clr_cnt_d  = '0;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        sp_d = '0;
        if (!i_regu_flag) begin
          state_d = ST_IDLE;
        end else if (clr_cnt == CLR_LAST) begin
          state_d = ST_FAULT;
        end else begin
          clr_cnt_d = clr_cnt + 16'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sp_d     = '0;
        target_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_set_point <= '0;
      target      <= '0;
      clr_cnt     <= '0;
      o_done      <= 1'b0;
      o_intl_clr  <= 1'b0;
      o_fault     <= 1'b0;
      o_regu_en   <= 1'b0;
    end else begin
      state       <= state_d;
      o_set_point <= sp_d;
      target      <= target_d;
      clr_cnt     <= clr_cnt_d;
      o_done      <= done_d;
      o_intl_clr  <= intl_clr_d;
      // Both follow the state being entered so they change with it.
      o_fault     <= is_fault_state(state_d);
      o_regu_en   <= i_regu_en && !is_fault_state(state_d);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_regu_sp_ctrl.sv
module tb_regu_sp_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_step;
  logic [31:0] i_period;
  logic        i_regu_en;
  logic        i_regu_flag;
  logic        i_clr_req;
  logic [31:0] o_set_point;
  logic        o_regu_en;
  logic        o_intl_clr;
  logic        o_done;
  logic        o_fault;
  logic [2:0]  o_state;

  int     total;
  int     bad;
  longint model_sp;

  regu_sp_ctrl_if cmd_if ();

  regu_sp_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .cmd         (cmd_if),
    .i_step      (i_step),
    .i_period    (i_period),
    .i_regu_en   (i_regu_en),
    .i_regu_flag (i_regu_flag),
    .i_clr_req   (i_clr_req),
    .o_set_point (o_set_point),
    .o_regu_en   (o_regu_en),
    .o_intl_clr  (o_intl_clr),
    .o_done      (o_done),
    .o_fault     (o_fault),
    .o_state     (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc();
    cyc();
    i_rst = 1'b0;
    cyc();
    model_sp = 0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    cyc();
    cyc();
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL reset_state act=%0d req=0", o_state); end
    total++; if (o_set_point !== 32'd0) begin bad++; $display("FAIL reset_sp act=%0h req=0", o_set_point); end
    total++; if ({o_done, o_intl_clr, o_fault, o_regu_en} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags act=%b req=0000", {o_done, o_intl_clr, o_fault, o_regu_en});
    end
    i_rst = 1'b0;
    cyc();
    total++; if (o_regu_en !== 1'b1) begin bad++; $display("FAIL reset_regu_en_idle act=%0b req=1", o_regu_en); end
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready act=%0b req=1", cmd_if.cmd_ready); end
    model_sp = 0;
  endtask

  // Expected set point after j visible ticks is sp0 moved toward the target by
  // min(j*step, |target-sp0|); the j-th tick becomes visible (j*(period+1)+1)
  // cycles after the command edge.
  task automatic run_ramp(input longint tgt, input longint stp, input int per);
    longint      d;
    longint      mag;
    longint      n;
    longint      j;
    longint      e;
    logic [31:0] e32;
    int          last;
    d   = tgt - model_sp;
    mag = (d < 0) ? -d : d;
    n   = (stp == 0 || mag <= stp) ? 1 : (mag + stp - 1) / stp;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 32'(tgt);
    i_step            = 32'(stp);
    i_period          = 32'(per);
    #1;
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL ramp_ready act=%0b req=1", cmd_if.cmd_ready); end
    cyc();
    cmd_if.cmd_valid = 1'b0;
    last = int'(n) * (per + 1) + 1;
    for (int c = 1; c <= last + 1; c++) begin
      j = longint'((c - 1) / (per + 1));
      if (j > n) j = n;
      e   = (j == n) ? tgt : ((d < 0) ? model_sp - j * stp : model_sp + j * stp);
      e32 = 32'(e);
      total++; if (o_set_point !== e32) begin
        bad++; $display("FAIL ramp_sp c=%0d act=%0d req=%0d", c, $signed(o_set_point), $signed(e32));
      end
      total++; if (o_done !== (c == last)) begin
        bad++; $display("FAIL ramp_done c=%0d act=%0b req=%0b", c, o_done, (c == last));
      end
      total++; if (o_state !== ((c >= last) ? 3'd0 : 3'd1)) begin
        bad++; $display("FAIL ramp_state c=%0d act=%0d req=%0d", c, o_state, (c >= last) ? 0 : 1);
      end
      if (c <= last) cyc();
    end
    model_sp = tgt;
  endtask

  task automatic test_ramp_basic();
    run_ramp(35, 10, 0);
    run_ramp(-1000, 0, 3);
  endtask

  task automatic test_boundaries();
    run_ramp(2147483647, 64'hFFFF_FFFF, 0);
    run_ramp(longint'(-2147483647) - 1, 64'h8000_0000, 1);
    run_ramp(2147483647, 64'hFFFF_FFFF, 0);
    run_ramp(2147483647, 5, 2);
    run_ramp(0, 64'h7FFF_FFFF, 0);
    run_ramp(0, 3, 1);
  endtask

  task automatic test_random_ramps();
    longint tgt;
    longint mag;
    longint stp;
    int     k;
    for (int i = 0; i < 12; i++) begin
      tgt = longint'($urandom_range(10000)) - 5000;
      mag = (tgt > model_sp) ? tgt - model_sp : model_sp - tgt;
      k   = int'($urandom_range(10));
      stp = (k == 0) ? 0 : mag / k + longint'($urandom_range(1));
      run_ramp(tgt, stp, int'($urandom_range(3)));
    end
  endtask

  task automatic test_retarget();
    int found;
    do_reset();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd100; i_step = 32'd10; i_period = 32'd0;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (o_set_point == 32'd40) found = 1; else cyc();
    end
    total++; if (found != 1) begin bad++; $display("FAIL retarget_reach40 act=%0d req=40", $signed(o_set_point)); end
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd20;
    #1;
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL retarget_ready act=%0b req=1", cmd_if.cmd_ready); end
    cyc();
    cmd_if.cmd_valid = 1'b0;
    total++; if (o_set_point !== 32'd30 || o_done !== 1'b0) begin
      bad++; $display("FAIL retarget_30 act=%0d/%0b req=30/0", $signed(o_set_point), o_done);
    end
    cyc();
    total++; if (o_set_point !== 32'd20 || o_done !== 1'b1 || o_state !== 3'd0) begin
      bad++; $display("FAIL retarget_20 act=%0d/%0b/%0d req=20/1/0", $signed(o_set_point), o_done, o_state);
    end
    // Tick phase must survive the retarget: period 2, retarget one cycle
    // after a tick, so the next tick is two cycles later.
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd50; i_period = 32'd2;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    total++; if (o_set_point !== 32'd30) begin bad++; $display("FAIL phase_pre act=%0d req=30", $signed(o_set_point)); end
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd20;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    total++; if (o_set_point !== 32'd30 || o_done !== 1'b0) begin
      bad++; $display("FAIL phase_hold act=%0d/%0b req=30/0", $signed(o_set_point), o_done);
    end
    cyc();
    total++; if (o_set_point !== 32'd20 || o_done !== 1'b1 || o_state !== 3'd0) begin
      bad++; $display("FAIL phase_tick act=%0d/%0b/%0d req=20/1/0", $signed(o_set_point), o_done, o_state);
    end
    model_sp = 20;
  endtask

  task automatic test_fault();
    int found;
    do_reset();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd100; i_step = 32'd10; i_period = 32'd0;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (o_set_point == 32'd50) found = 1; else cyc();
    end
    total++; if (found != 1) begin bad++; $display("FAIL fault_reach50 act=%0d req=50", $signed(o_set_point)); end
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd7; i_regu_flag = 1'b1;
    #1;
    total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL fault_ready act=%0b req=0", cmd_if.cmd_ready); end
    cyc();
    cmd_if.cmd_valid = 1'b0;
    total++; if (o_set_point !== 32'd0 || o_fault !== 1'b1 || o_regu_en !== 1'b0 || o_state !== 3'd2 || o_done !== 1'b0) begin
      bad++; $display("FAIL fault_entry act=sp%0d f%0b en%0b st%0d d%0b req=sp0 f1 en0 st2 d0",
                      $signed(o_set_point), o_fault, o_regu_en, o_state, o_done);
    end
    i_regu_flag = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    #1;
    total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL fault_refuse act=%0b req=0", cmd_if.cmd_ready); end
    cyc();
    cmd_if.cmd_valid = 1'b0;
    total++; if (o_state !== 3'd2 || o_set_point !== 32'd0) begin
      bad++; $display("FAIL fault_hold act=%0d/%0d req=2/0", o_state, $signed(o_set_point));
    end
    model_sp = 0;
  endtask

  task automatic test_clear();
    int n_clear;
    int pulses;
    // entered with the DUT in FAULT
    i_regu_flag = 1'b1; i_clr_req = 1'b1;
    cyc();
    i_clr_req = 1'b0;
    total++; if (o_intl_clr !== 1'b1 || o_state !== 3'd3 || o_fault !== 1'b1) begin
      bad++; $display("FAIL clear_pulse act=%0b/%0d/%0b req=1/3/1", o_intl_clr, o_state, o_fault);
    end
    cyc();
    total++; if (o_intl_clr !== 1'b0 || o_state !== 3'd3) begin
      bad++; $display("FAIL clear_one_cycle act=%0b/%0d req=0/3", o_intl_clr, o_state);
    end
    i_regu_flag = 1'b0;
    cyc();
    total++; if (o_state !== 3'd0 || o_fault !== 1'b0 || o_regu_en !== 1'b1 || o_intl_clr !== 1'b0) begin
      bad++; $display("FAIL clear_to_idle act=%0d/%0b/%0b/%0b req=0/0/1/0", o_state, o_fault, o_regu_en, o_intl_clr);
    end
    i_clr_req = 1'b1;
    cyc();
    i_clr_req = 1'b0;
    total++; if (o_intl_clr !== 1'b0 || o_state !== 3'd0) begin
      bad++; $display("FAIL clear_ignored act=%0b/%0d req=0/0", o_intl_clr, o_state);
    end
    i_regu_flag = 1'b1;
    cyc();
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL timeout_fault act=%0d req=2", o_state); end
    i_clr_req = 1'b1;
    cyc();
    i_clr_req = 1'b0;
    total++; if (o_intl_clr !== 1'b1 || o_state !== 3'd3) begin
      bad++; $display("FAIL timeout_pulse act=%0b/%0d req=1/3", o_intl_clr, o_state);
    end
    n_clear = 1;
    pulses  = 0;
    for (int c = 0; c < 40 && o_state != 3'd2; c++) begin
      cyc();
      if (o_state == 3'd3) n_clear++;
      if (o_intl_clr) pulses++;
    end
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL timeout_back act=%0d req=2", o_state); end
    total++; if (n_clear != 16) begin bad++; $display("FAIL timeout_len act=%0d req=16", n_clear); end
    total++; if (pulses != 0) begin bad++; $display("FAIL timeout_repulse act=%0d req=0", pulses); end
    cyc();
    total++; if (o_state !== 3'd2 || o_intl_clr !== 1'b0 || o_fault !== 1'b1) begin
      bad++; $display("FAIL timeout_stay act=%0d/%0b/%0b req=2/0/1", o_state, o_intl_clr, o_fault);
    end
    i_regu_flag = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 32'd1000; i_step = 32'd1; i_period = 32'd0;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) cyc();
    total++; if (o_state !== 3'd1) begin bad++; $display("FAIL rst_ramp_pre act=%0d req=1", o_state); end
    i_rst = 1'b1;
    cyc();
    total++; if (o_state !== 3'd0 || o_set_point !== 32'd0 || {o_done, o_intl_clr, o_fault, o_regu_en} !== 4'b0000) begin
      bad++; $display("FAIL rst_ramp act=st%0d sp%0d fl%b req=st0 sp0 fl0000",
                      o_state, $signed(o_set_point), {o_done, o_intl_clr, o_fault, o_regu_en});
    end
    i_rst = 1'b0;
    i_regu_flag = 1'b1;
    cyc();
    i_clr_req = 1'b1;
    cyc();
    total++; if (o_state !== 3'd3) begin bad++; $display("FAIL rst_clear_pre act=%0d req=3", o_state); end
    i_rst = 1'b1;
    cyc();
    total++; if (o_state !== 3'd0 || o_set_point !== 32'd0 || {o_done, o_intl_clr, o_fault, o_regu_en} !== 4'b0000) begin
      bad++; $display("FAIL rst_clear act=st%0d sp%0d fl%b req=st0 sp0 fl0000",
                      o_state, $signed(o_set_point), {o_done, o_intl_clr, o_fault, o_regu_en});
    end
    i_clr_req = 1'b0; i_regu_flag = 1'b0; i_rst = 1'b0;
    cyc();
    total++; if (o_state !== 3'd0 || o_intl_clr !== 1'b0 || o_regu_en !== 1'b1) begin
      bad++; $display("FAIL rst_release act=%0d/%0b/%0b req=0/0/1", o_state, o_intl_clr, o_regu_en);
    end
    model_sp = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_sp = 0;
    i_rst = 1'b1;
    i_step = 32'd0;
    i_period = 32'd0;
    i_regu_en = 1'b1;
    i_regu_flag = 1'b0;
    i_clr_req = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_target = 32'd0;
    @(negedge i_clk);
    test_reset();
    test_ramp_basic();
    test_boundaries();
    test_random_ramps();
    test_retarget();
    test_fault();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

endmodule
